// File: rtl/mu0_pkg.sv
// MU0 control shared definitions: opcodes, ALU function codes, FSM state
// encoding and the packed control word passed from decoder to top.
package mu0_pkg;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_JMP = 4'h4;
    localparam logic [3:0] OP_JGE = 4'h5;
    localparam logic [3:0] OP_JNE = 4'h6;
    localparam logic [3:0] OP_STP = 4'h7;

    localparam logic [1:0] ALU_Y   = 2'b00;
    localparam logic [1:0] ALU_ADD = 2'b01;
    localparam logic [1:0] ALU_SUB = 2'b10;
    localparam logic [1:0] ALU_INC = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_t;

    typedef struct packed {
        logic       asel;
        logic       xsel;
        logic       ysel;
        logic [1:0] alufs;
        logic       accce;
        logic       pcce;
        logic       irce;
        logic       accoe;
        logic       memrq;
        logic       rnw;
    } ctrl_t;

    // Quiescent word: nothing enabled, bus in read direction.
    localparam ctrl_t CTRL_IDLE = '{asel: 1'b0, xsel: 1'b0, ysel: 1'b0,
                                    alufs: ALU_Y, accce: 1'b0, pcce: 1'b0,
                                    irce: 1'b0, accoe: 1'b0, memrq: 1'b0,
                                    rnw: 1'b1};

    // LDA/STA/ADD/SUB are the only opcodes that touch memory in EXEC.
    function automatic logic is_mem_op(input logic [3:0] op);
        return (op[3:2] == 2'b00);
    endfunction

endpackage

// File: rtl/mu0_ctrl_decode.sv
// Combinational decode of (state, opcode, flags) into the datapath control
// word. Wait-state gating of the enables is applied by the top level.
module mu0_ctrl_decode
    import mu0_pkg::*;
(
    input  state_t     state,
    input  logic [3:0] ir_op,
    input  logic       n,
    input  logic       z,
    output ctrl_t      ctrl
);

    // Control word per state; EXEC decodes the opcode, flags only matter there.
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state)
            ST_FETCH: begin
                ctrl.asel  = 1'b0;
                ctrl.memrq = 1'b1;
                ctrl.rnw   = 1'b1;
                ctrl.irce  = 1'b1;
                ctrl.xsel  = 1'b1;
                ctrl.alufs = ALU_INC;
                ctrl.pcce  = 1'b1;
            end
            ST_EXEC: begin
                case (ir_op)
                    OP_LDA: begin
                        ctrl.asel  = 1'b1;
                        ctrl.memrq = 1'b1;
                        ctrl.alufs = ALU_Y;
                        ctrl.accce = 1'b1;
                    end
                    OP_STA: begin
                        ctrl.asel  = 1'b1;
                        ctrl.memrq = 1'b1;
                        ctrl.rnw   = 1'b0;
                        ctrl.accoe = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.asel  = 1'b1;
                        ctrl.memrq = 1'b1;
                        ctrl.alufs = (ir_op == OP_ADD) ? ALU_ADD : ALU_SUB;
                        ctrl.accce = 1'b1;
                    end
                    OP_JMP, OP_JGE, OP_JNE: begin
                        // Conditional jumps degrade to NOP when not taken.
                        if ((ir_op == OP_JMP) ||
                            (ir_op == OP_JGE && !n) ||
                            (ir_op == OP_JNE && !z)) begin
                            ctrl.ysel  = 1'b1;
                            ctrl.alufs = ALU_Y;
                            ctrl.pcce  = 1'b1;
                        end
                    end
                    default: ctrl = CTRL_IDLE;   // STP and NOPs
                endcase
            end
            default: ctrl = CTRL_IDLE;           // IDLE and HALT
        endcase
    end

endmodule

// File: rtl/mu0_control.sv
// MU0 control unit top: state register, memory wait handling, retired
// instruction counter and enable gating around the combinational decoder.
// Optional feature macro: MU0_MEMWAIT_EN (Mem_ack wait-state handshake).
module mu0_control
    import mu0_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             Clk,
    input  logic             nReset,
    input  logic [3:0]       IR_op,
    input  logic             N,
    input  logic             Z,
    input  logic             Mem_ack,
    output logic             Asel,
    output logic             Xsel,
    output logic             Ysel,
    output logic [1:0]       ALUfs,
    output logic             ACCce,
    output logic             PCce,
    output logic             IRce,
    output logic             ACCoe,
    output logic             MEMrq,
    output logic             RnW,
    output logic             Halted,
    output logic [CNT_W-1:0] Instr_cnt
);

    state_t     state, state_nx;
    ctrl_t      dec, ctrl;
    logic       ack;
    logic       mem_phase;
    logic       stall;
    logic [CNT_W-1:0] cnt;

`ifdef MU0_MEMWAIT_EN
    assign ack = Mem_ack;
`else
    // Without the handshake every access completes in one cycle.
    logic unused_mem_ack;
    assign unused_mem_ack = Mem_ack;
    assign ack = 1'b1;
`endif

    mu0_ctrl_decode u_dec (
        .state (state),
        .ir_op (IR_op),
        .n     (N),
        .z     (Z),
        .ctrl  (dec)
    );

    assign mem_phase = (state == ST_FETCH) ||
                       (state == ST_EXEC && is_mem_op(IR_op));
    assign stall     = mem_phase && !ack;

    // State register; reset lands in IDLE from any state.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) state <= ST_IDLE;
        else         state <= state_nx;
    end

    // Next state and gated control word: addresses/mux selects stay put
    // during a stall, register enables only fire on the completing cycle.
    always_comb begin
        state_nx = state;
        ctrl     = dec;
        if (stall) begin
            ctrl.irce  = 1'b0;
            ctrl.pcce  = 1'b0;
            ctrl.accce = 1'b0;
        end
        case (state)
            ST_IDLE:  state_nx = ST_FETCH;
            ST_FETCH: if (!stall) state_nx = ST_EXEC;
            ST_EXEC:  if (!stall) state_nx = (IR_op == OP_STP) ? ST_HALT : ST_FETCH;
            ST_HALT:  state_nx = ST_HALT;
            default:  state_nx = ST_IDLE;
        endcase
    end

    // Retired-instruction counter: bumps on each completed EXEC, saturates.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset)
            cnt <= '0;
        else if (state == ST_EXEC && !stall && cnt != {CNT_W{1'b1}})
            cnt <= cnt + 1'b1;
    end

    assign Asel      = ctrl.asel;
    assign Xsel      = ctrl.xsel;
    assign Ysel      = ctrl.ysel;
    assign ALUfs     = ctrl.alufs;
    assign ACCce     = ctrl.accce;
    assign PCce      = ctrl.pcce;
    assign IRce      = ctrl.irce;
    assign ACCoe     = ctrl.accoe;
    assign MEMrq     = ctrl.memrq;
    assign RnW       = ctrl.rnw;
    assign Halted    = (state == ST_HALT);
    assign Instr_cnt = cnt;

endmodule
